// File: rtl/icache_line_buffer.sv
// ============================================================================
// Module   : icache_line_buffer
// Purpose  : Direct-mapped, one-word-per-line instruction cache between a
//            fetcher and a program memory controller. Optional hit/miss
//            counters are enabled by defining ICACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_line_buffer #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int NUM_LINES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 consumer_read_valid,
    input  logic [ADDR_BITS-1:0] consumer_read_address,
    output logic                 consumer_read_ready,
    output logic [DATA_BITS-1:0] consumer_read_data,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    input  logic                 flush
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
`endif
);

    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        RELAY     = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic                   flush_pending_q, flush_pending_d;
    logic                   ready_q, ready_d;
    logic [DATA_BITS-1:0]   rdata_q, rdata_d;
    logic                   mvalid_q, mvalid_d;
    logic [ADDR_BITS-1:0]   maddr_q, maddr_d;
    logic                   fill_we;

    logic [TAG_BITS-1:0]    tag_q  [NUM_LINES];
    logic [DATA_BITS-1:0]   data_q [NUM_LINES];

    logic [IDX_BITS-1:0]    req_idx;
    logic [TAG_BITS-1:0]    req_tag;
    logic [IDX_BITS-1:0]    fill_idx;
    logic [TAG_BITS-1:0]    fill_tag;
    logic                   hit;
    logic                   idle_flush;

    assign req_idx    = consumer_read_address[IDX_BITS-1:0];
    assign req_tag    = consumer_read_address[ADDR_BITS-1:IDX_BITS];
    assign fill_idx   = maddr_q[IDX_BITS-1:0];
    assign fill_tag   = maddr_q[ADDR_BITS-1:IDX_BITS];
    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // A deferred flush behaves exactly like a fresh one on the first IDLE cycle
    assign idle_flush = flush || flush_pending_q;

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        flush_pending_d = flush_pending_q;
        ready_d         = ready_q;
        rdata_d         = rdata_q;
        mvalid_d        = mvalid_q;
        maddr_d         = maddr_q;
        fill_we         = 1'b0;
        case (state_q)
            IDLE: begin
                if (idle_flush) begin
                    valid_d         = '0;
                    flush_pending_d = 1'b0;
                end else if (consumer_read_valid) begin
                    if (hit) begin
                        ready_d = 1'b1;
                        rdata_d = data_q[req_idx];
                        state_d = RELAY;
                    end else begin
                        mvalid_d = 1'b1;
                        maddr_d  = consumer_read_address;
                        state_d  = MISS_WAIT;
                    end
                end
            end
            MISS_WAIT: begin
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                if (mem_read_ready) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    mvalid_d          = 1'b0;
                    ready_d           = 1'b1;
                    rdata_d           = mem_read_data;
                    state_d           = RELAY;
                end
            end
            RELAY: begin
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                if (!consumer_read_valid) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
            ready_q         <= 1'b0;
            rdata_q         <= '0;
            mvalid_q        <= 1'b0;
            maddr_q         <= '0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            flush_pending_q <= flush_pending_d;
            ready_q         <= ready_d;
            rdata_q         <= rdata_d;
            mvalid_q        <= mvalid_d;
            maddr_q         <= maddr_d;
        end
    end

    // Tag/data storage carries no reset; the valid bits alone qualify it
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_read_data;
        end
    end

    assign consumer_read_ready = ready_q;
    assign consumer_read_data  = rdata_q;
    assign mem_read_valid      = mvalid_q;
    assign mem_read_address    = maddr_q;

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;
    logic        hit_evt, miss_evt;

    assign hit_evt  = (state_q == IDLE) && !idle_flush && consumer_read_valid && hit;
    assign miss_evt = (state_q == IDLE) && !idle_flush && consumer_read_valid && !hit;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_evt && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (miss_evt && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_line_buffer.sv
// ============================================================================
// Module   : tb_icache_line_buffer
// Purpose  : Self-checking bench for icache_line_buffer against a
//            transaction-level cache model (directed + randomized reads).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_line_buffer;

    localparam int AB = 8;
    localparam int DB = 16;
    localparam int NL = 16;

    logic          clk;
    logic          reset;
    logic          consumer_read_valid;
    logic [AB-1:0] consumer_read_address;
    logic          consumer_read_ready;
    logic [DB-1:0] consumer_read_data;
    logic          mem_read_valid;
    logic [AB-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DB-1:0] mem_read_data;
    logic          flush;
`ifdef ICACHE_STATS_EN
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;
`endif

    icache_line_buffer #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_LINES(NL)) dut (
        .clk                  (clk),
        .reset                (reset),
        .consumer_read_valid  (consumer_read_valid),
        .consumer_read_address(consumer_read_address),
        .consumer_read_ready  (consumer_read_ready),
        .consumer_read_data   (consumer_read_data),
        .mem_read_valid       (mem_read_valid),
        .mem_read_address     (mem_read_address),
        .mem_read_ready       (mem_read_ready),
        .mem_read_data        (mem_read_data),
        .flush                (flush)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count            (hit_count),
        .miss_count           (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cache contents plus expected output values
    logic          m_valid [NL];
    logic [3:0]    m_tag   [NL];
    logic [DB-1:0] m_data  [NL];
    bit            m_pend;
    int            m_hits, m_misses;
    logic          exp_ready, exp_mvalid;
    logic [DB-1:0] exp_data;
    logic [AB-1:0] exp_maddr;

    int  checks, failures;
    int  mreq_cnt;
    bit  mv_prev;
    bit  chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("consumer_read_ready", {31'd0, consumer_read_ready}, {31'd0, exp_ready});
            chk("consumer_read_data", {16'd0, consumer_read_data}, {16'd0, exp_data});
            chk("mem_read_valid", {31'd0, mem_read_valid}, {31'd0, exp_mvalid});
            chk("mem_read_address", {24'd0, mem_read_address}, {24'd0, exp_maddr});
`ifdef ICACHE_STATS_EN
            chk("hit_count", {16'd0, hit_count}, m_hits);
            chk("miss_count", {16'd0, miss_count}, m_misses);
`endif
        end
        if (mem_read_valid && !mv_prev) mreq_cnt++;
        mv_prev = mem_read_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic idle_tick(input bit fl);
        consumer_read_valid   = 1'b0;
        consumer_read_address = AB'($urandom);
        flush                 = fl;
        mem_read_ready        = 1'b0;
        mem_read_data         = DB'($urandom);
        tick();
        if (fl || m_pend) model_clear();
        flush = 1'b0;
    endtask

    task automatic do_read(input logic [AB-1:0] addr, input bit fl_req, input int lat,
                           input int fl_miss_cyc, input int hold, input bit fl_relay,
                           input bit fixed, input logic [DB-1:0] fdata, output bit was_hit);
        int            idx;
        logic [DB-1:0] d;
        idx = int'(addr % NL);
        consumer_read_valid   = 1'b1;
        consumer_read_address = addr;
        mem_read_ready        = 1'b0;
        mem_read_data         = DB'($urandom);
        flush                 = fl_req;
        if (fl_req || m_pend) begin
            tick();
            model_clear();
            flush = 1'b0;
        end
        was_hit = m_valid[idx] && (m_tag[idx] == addr[AB-1:4]);
        tick();
        if (was_hit) begin
            m_hits++;
            exp_ready = 1'b1;
            exp_data  = m_data[idx];
        end else begin
            m_misses++;
            exp_mvalid = 1'b1;
            exp_maddr  = addr;
            for (int c = 0; c < lat; c++) begin
                flush         = (c == fl_miss_cyc);
                mem_read_data = DB'($urandom);
                tick();
                if (flush) m_pend = 1'b1;
                flush = 1'b0;
            end
            d              = fixed ? fdata : DB'($urandom);
            mem_read_ready = 1'b1;
            mem_read_data  = d;
            tick();
            mem_read_ready = 1'b0;
            mem_read_data  = DB'($urandom);
            m_valid[idx]   = 1'b1;
            m_tag[idx]     = addr[AB-1:4];
            m_data[idx]    = d;
            exp_mvalid     = 1'b0;
            exp_ready      = 1'b1;
            exp_data       = d;
        end
        for (int h = 0; h < hold; h++) begin
            flush = fl_relay && (h == 0);
            tick();
            if (flush) m_pend = 1'b1;
            flush = 1'b0;
        end
        consumer_read_valid   = 1'b0;
        consumer_read_address = AB'($urandom);
        tick();
        exp_ready = 1'b0;
    endtask

    bit h;

    initial begin
        checks = 0; failures = 0; mreq_cnt = 0; mv_prev = 0; chk_en = 0;
        m_hits = 0; m_misses = 0;
        model_clear();
        exp_ready = 0; exp_data = '0; exp_mvalid = 0; exp_maddr = '0;
        reset = 1'b0; consumer_read_valid = 0; consumer_read_address = '0;
        mem_read_ready = 0; mem_read_data = '0; flush = 0;
        repeat (3) tick();
        chk("reset_ready", {31'd0, consumer_read_ready}, 32'd0);
        chk("reset_mvalid", {31'd0, mem_read_valid}, 32'd0);
        chk("reset_data", {16'd0, consumer_read_data}, 32'd0);
        chk("reset_maddr", {24'd0, mem_read_address}, 32'd0);
        reset  = 1'b1;
        chk_en = 1'b1;
        idle_tick(0);

        // Cold read of 0x05, fill after 3 cycles
        do_read(8'h05, 0, 3, -1, 1, 0, 1, 16'hA1B2, h);
        chk("cold_is_miss", {31'd0, h}, 32'd0);
        chk("cold_data_held", {16'd0, consumer_read_data}, 32'h0000A1B2);
        chk("cold_one_request", mreq_cnt, 32'd1);
        idle_tick(0);

        // Warm read of 0x05
        do_read(8'h05, 0, 0, -1, 0, 0, 0, '0, h);
        chk("warm_is_hit", {31'd0, h}, 32'd1);
        chk("warm_data", {16'd0, consumer_read_data}, 32'h0000A1B2);
        chk("warm_no_request", mreq_cnt, 32'd1);

        // Conflict sequence on index 5 from a cold cache
        idle_tick(1);
        do_read(8'h05, 0, 1, -1, 0, 0, 0, '0, h);
        chk("conflict_a_miss", {31'd0, h}, 32'd0);
        do_read(8'h15, 0, 2, -1, 0, 0, 0, '0, h);
        chk("conflict_b_miss", {31'd0, h}, 32'd0);
        do_read(8'h05, 0, 0, -1, 0, 0, 0, '0, h);
        chk("conflict_c_miss", {31'd0, h}, 32'd0);
        chk("conflict_requests", mreq_cnt, 32'd4);
`ifdef ICACHE_STATS_EN
        chk("stats_hits", {16'd0, hit_count}, 32'd1);
        chk("stats_misses", {16'd0, miss_count}, 32'd4);
`endif

        // Flush coincident with a request to cached 0x05
        do_read(8'h05, 1, 2, -1, 0, 0, 0, '0, h);
        chk("flush_req_miss", {31'd0, h}, 32'd0);
        // Flush during the fill, then re-read misses
        do_read(8'h05, 0, 3, 1, 1, 0, 0, '0, h);
        chk("pre_flush_hit", {31'd0, h}, 32'd1);
        do_read(8'h25, 0, 3, 1, 1, 0, 0, '0, h);
        chk("fill_flush_miss", {31'd0, h}, 32'd0);
        do_read(8'h25, 0, 1, -1, 0, 0, 0, '0, h);
        chk("after_fill_flush_miss", {31'd0, h}, 32'd0);

        // Reset in the middle of a miss
        consumer_read_valid   = 1'b1;
        consumer_read_address = 8'h33;
        tick();
        m_misses++;
        exp_mvalid = 1'b1;
        exp_maddr  = 8'h33;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_mvalid", {31'd0, mem_read_valid}, 32'd0);
        chk("async_rst_maddr", {24'd0, mem_read_address}, 32'd0);
        chk("async_rst_ready", {31'd0, consumer_read_ready}, 32'd0);
        chk("async_rst_data", {16'd0, consumer_read_data}, 32'd0);
        model_clear();
        m_hits = 0; m_misses = 0;
        exp_mvalid = 0; exp_maddr = '0; exp_ready = 0; exp_data = '0;
        consumer_read_valid = 1'b0;
        tick();
        reset          = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        tick();
        tick();
        mem_read_ready = 1'b0;
        do_read(8'h33, 0, 1, -1, 0, 0, 0, '0, h);
        chk("post_reset_miss", {31'd0, h}, 32'd0);

        // Randomized traffic over a small address window to mix hits and misses
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) idle_tick($urandom_range(0, 5) == 0);
            do_read(AB'($urandom_range(0, 47)), $urandom_range(0, 9) == 0,
                    $urandom_range(0, 4),
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1,
                    $urandom_range(0, 2), $urandom_range(0, 7) == 0, 0, '0, h);
        end
        idle_tick(0);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
